// File: rtl/mac_dot_sequencer.sv
// rtl/mac_dot_sequencer.sv - K-step dot-product sequencer feeding a fixed-latency MAC
// Feeds each MAC result back as IN3 and returns the final accumulator with sticky flags.
module mac_dot_sequencer #(
  parameter int MAC_LAT = 2,
  parameter int KW      = 8,
  parameter int PARM_RM = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [2:0]         cfg_mode,
  input  logic [PARM_RM-1:0] cfg_rm,
  input  logic [KW-1:0]      cfg_k,
  input  logic [127:0]       cfg_acc_init,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [31:0]        op_a,
  input  logic [31:0]        op_b,
  output logic [31:0]        mac_in1,
  output logic [31:0]        mac_in2,
  output logic [127:0]       mac_in3,
  output logic [2:0]         mac_mode,
  output logic [PARM_RM-1:0] mac_rm,
  input  logic [127:0]       mac_out,
  input  logic               mac_nv,
  input  logic               mac_of,
  input  logic               mac_uf,
  input  logic               mac_nx,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [127:0]       res_data,
  output logic [3:0]         res_flags,
  output logic               busy
);

  localparam int WW = (MAC_LAT < 2) ? 1 : $clog2(MAC_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t               state, state_nxt;
  logic [2:0]           mode_q;
  logic [PARM_RM-1:0]   rm_q;
  logic [KW-1:0]        k_q;
  logic [KW-1:0]        step_cnt;
  logic [KW-1:0]        step_nxt;
  logic [WW-1:0]        wcnt;
  logic [127:0]         acc;
  logic [3:0]           flags;
  logic [31:0]          in1_q, in2_q;
  logic                 last_tick;
  logic                 cfg_short;

  assign step_nxt  = step_cnt + 1'b1;
  assign last_tick = (state == WAIT) && (wcnt == WW'(1));
  // Zero-length and illegal-mode jobs skip straight to DONE with acc_init as the result.
  assign cfg_short = (cfg_k == '0) || (cfg_mode == 3'b111);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_valid) state_nxt = cfg_short ? DONE : ISSUE;
      ISSUE:   if (op_valid) state_nxt = WAIT;
      WAIT:    if (last_tick) state_nxt = (step_nxt == k_q) ? DONE : ISSUE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      mode_q   <= '0;
      rm_q     <= '0;
      k_q      <= '0;
      step_cnt <= '0;
      wcnt     <= '0;
      acc      <= '0;
      flags    <= '0;
      in1_q    <= '0;
      in2_q    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (cfg_valid) begin
          mode_q   <= cfg_mode;
          rm_q     <= cfg_rm;
          k_q      <= cfg_k;
          acc      <= cfg_acc_init;
          step_cnt <= '0;
          wcnt     <= '0;
          flags    <= (cfg_k != '0 && cfg_mode == 3'b111) ? 4'b1000 : 4'b0000;
        end
        ISSUE: if (op_valid) begin
          in1_q <= op_a;
          in2_q <= op_b;
          wcnt  <= WW'(MAC_LAT);
        end
        WAIT: begin
          wcnt <= wcnt - 1'b1;
          // MAC OUT is stable exactly MAC_LAT edges after the operands were registered.
          if (last_tick) begin
            acc      <= mac_out;
            flags    <= flags | {mac_nv, mac_of, mac_uf, mac_nx};
            step_cnt <= step_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign cfg_ready = (state == IDLE);
  assign op_ready  = (state == ISSUE);
  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign mac_in1   = in1_q;
  assign mac_in2   = in2_q;
  assign mac_in3   = acc;
  assign mac_mode  = mode_q;
  assign mac_rm    = rm_q;
  assign res_data  = acc;
  assign res_flags = flags;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// tb/tb_mac_dot_sequencer.sv - directed bench for mac_dot_sequencer with a MAC stub
// Stub: OUT = IN3 + IN1*IN2 registered once (stable by MAC_LAT=2), OF when IN1 is all ones.
module tb_mac_dot_sequencer;
  localparam int KW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid, cfg_ready;
  logic [2:0]    cfg_mode;
  logic [2:0]    cfg_rm;
  logic [KW-1:0] cfg_k;
  logic [127:0]  cfg_acc_init;
  logic          op_valid, op_ready;
  logic [31:0]   op_a, op_b;
  logic [31:0]   mac_in1, mac_in2;
  logic [127:0]  mac_in3;
  logic [2:0]    mac_mode;
  logic [2:0]    mac_rm;
  logic [127:0]  mac_out;
  logic          mac_nv, mac_of, mac_uf, mac_nx;
  logic          res_valid, res_ready;
  logic [127:0]  res_data;
  logic [3:0]    res_flags;
  logic          busy;

  int checks = 0;
  int failures = 0;
  logic [31:0] opa [16];
  logic [31:0] opb [16];
  int lat;
  bit to;
  bit saw_ready;

  always #5 clk = ~clk;

  mac_dot_sequencer #(.MAC_LAT(2), .KW(KW), .PARM_RM(3)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mode(cfg_mode), .cfg_rm(cfg_rm),
    .cfg_k(cfg_k), .cfg_acc_init(cfg_acc_init),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .mac_in1(mac_in1), .mac_in2(mac_in2), .mac_in3(mac_in3), .mac_mode(mac_mode), .mac_rm(mac_rm),
    .mac_out(mac_out), .mac_nv(mac_nv), .mac_of(mac_of), .mac_uf(mac_uf), .mac_nx(mac_nx),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_flags(res_flags),
    .busy(busy)
  );

  always_ff @(posedge clk) begin
    mac_out <= mac_in3 + {64'd0, 64'(mac_in1) * 64'(mac_in2)};
    mac_of  <= (mac_in1 == 32'hFFFF_FFFF);
  end
  assign mac_nv = 1'b0;
  assign mac_uf = 1'b0;
  assign mac_nx = 1'b0;

  // Drives one job until res_valid; lat counts edges with the cfg accept edge as 1.
  task automatic run_job(input logic [2:0] mode, input logic [KW-1:0] k, input logic [127:0] init,
                         input int gap, input bit chk_wait);
    int n, gapc;
    bit acc_now, prev_wait, in_wait;
    logic [31:0] s1, s2;
    logic [127:0] s3;
    logic [2:0] sm;
    n = 0; gapc = 0; prev_wait = 0; to = 1; saw_ready = 0;
    s1 = '0; s2 = '0; s3 = '0; sm = '0;
    @(negedge clk);
    cfg_mode = mode; cfg_rm = 3'b010; cfg_k = k; cfg_acc_init = init; cfg_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    for (int it = 0; it < 500; it++) begin
      @(negedge clk);
      cfg_valid = 1'b0;
      if (op_ready) saw_ready = 1;
      if (res_valid) begin
        to = 0;
        break;
      end
      in_wait = busy && !op_ready && !res_valid;
      if (chk_wait && in_wait && prev_wait) begin
        checks++;
        if (mac_in1 !== s1 || mac_in2 !== s2 || mac_in3 !== s3 || mac_mode !== sm) begin
          failures++;
          $display("FAIL wait_hold in1=%0h/%0h in2=%0h/%0h in3=%0h/%0h mode=%0h/%0h",
                   mac_in1, s1, mac_in2, s2, mac_in3, s3, mac_mode, sm);
        end
      end
      prev_wait = in_wait;
      s1 = mac_in1; s2 = mac_in2; s3 = mac_in3; sm = mac_mode;
      if (gapc > 0) begin
        gapc--;
        op_valid = 1'b0;
      end else if (n < int'(k)) begin
        op_valid = 1'b1; op_a = opa[n]; op_b = opb[n];
      end else begin
        op_valid = 1'b0;
      end
      acc_now = op_valid && op_ready;
      @(posedge clk);
      lat++;
      if (acc_now) begin
        n++;
        gapc = gap;
      end
    end
    op_valid = 1'b0;
    checks++;
    if (to) begin
      failures++;
      $display("FAIL job_timeout res_valid never rose, required within 500 cycles");
    end
  endtask

  task automatic finish_job();
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (cfg_ready !== 1'b1) begin failures++; $display("FAIL rst_cfg_ready got=%0b exp=1", cfg_ready); end
    checks++;
    if ({op_ready, res_valid, busy} !== 3'b000) begin
      failures++; $display("FAIL rst_ctrl got=%b exp=000", {op_ready, res_valid, busy});
    end
    checks++;
    if (mac_in1 !== 0 || mac_in2 !== 0 || mac_in3 !== 0 || mac_mode !== 0 || mac_rm !== 0) begin
      failures++; $display("FAIL rst_mac got=%0h,%0h,%0h,%0h,%0h exp=0", mac_in1, mac_in2, mac_in3, mac_mode, mac_rm);
    end
    checks++;
    if (res_data !== 0 || res_flags !== 0) begin
      failures++; $display("FAIL rst_res got=%0h/%0h exp=0/0", res_data, res_flags);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    opa[0] = 2; opb[0] = 3; opa[1] = 4; opb[1] = 5; opa[2] = 1; opb[2] = 1;
    run_job(3'b100, 3, 128'd5, 0, 0);
    checks++;
    if (lat !== 10) begin failures++; $display("FAIL basic_latency got=%0d exp=10", lat); end
    checks++;
    if (res_data !== 128'd32) begin failures++; $display("FAIL basic_data got=%0h exp=20", res_data); end
    checks++;
    if (res_flags !== 4'b0000) begin failures++; $display("FAIL basic_flags got=%b exp=0000", res_flags); end
    checks++;
    if (mac_mode !== 3'b100 || mac_rm !== 3'b010) begin
      failures++; $display("FAIL basic_mode_rm got=%b/%b exp=100/010", mac_mode, mac_rm);
    end
    finish_job();
  endtask

  task automatic test_zero_illegal();
    run_job(3'b001, 0, 128'hABCD, 0, 0);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL zero_latency got=%0d exp=1", lat); end
    checks++;
    if (res_data !== 128'hABCD || res_flags !== 4'b0000) begin
      failures++; $display("FAIL zero_result got=%0h/%b exp=abcd/0000", res_data, res_flags);
    end
    checks++;
    if (saw_ready !== 1'b0) begin failures++; $display("FAIL zero_op_ready got=%0b exp=0", saw_ready); end
    finish_job();
    run_job(3'b111, 4, 128'h1234, 0, 0);
    checks++;
    if (lat !== 1 || saw_ready !== 1'b0) begin
      failures++; $display("FAIL illegal_latency got=%0d/%0b exp=1/0", lat, saw_ready);
    end
    checks++;
    if (res_data !== 128'h1234 || res_flags !== 4'b1000) begin
      failures++; $display("FAIL illegal_result got=%0h/%b exp=1234/1000", res_data, res_flags);
    end
    finish_job();
  endtask

  task automatic test_stall();
    opa[0] = 2; opb[0] = 3; opa[1] = 4; opb[1] = 5; opa[2] = 1; opb[2] = 1;
    run_job(3'b100, 3, 128'd5, 3, 1);
    checks++;
    if (res_data !== 128'd32 || res_flags !== 4'b0000) begin
      failures++; $display("FAIL stall_result got=%0h/%b exp=20/0000", res_data, res_flags);
    end
    checks++;
    if (lat !== 12) begin failures++; $display("FAIL stall_latency got=%0d exp=12", lat); end
    finish_job();
  endtask

  task automatic test_sticky();
    opa[0] = 32'hFFFF_FFFF; opb[0] = 1; opa[1] = 2; opb[1] = 3;
    run_job(3'b000, 2, 128'd0, 0, 0);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (res_valid !== 1'b1 || res_flags !== 4'b0100 || res_data !== 128'h1_0000_0005) begin
        failures++;
        $display("FAIL sticky_hold cyc=%0d got=%0b/%b/%0h exp=1/0100/100000005", c, res_valid, res_flags, res_data);
      end
      @(negedge clk);
    end
    checks++;
    if (cfg_ready !== 1'b0) begin failures++; $display("FAIL sticky_cfg_ready_done got=%0b exp=0", cfg_ready); end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    checks++;
    if (cfg_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL sticky_release got=%0b/%0b/%0b exp=1/0/0", cfg_ready, res_valid, busy);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    cfg_mode = 3'b000; cfg_rm = 3'b001; cfg_k = 4; cfg_acc_init = 128'd0; cfg_valid = 1'b1;
    op_valid = 1'b1; op_a = 32'hFFFF_FFFF; op_b = 1;
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (busy !== 1'b1 || op_ready !== 1'b0 || res_valid !== 1'b0) begin
      failures++; $display("FAIL midrst_in_wait got=%0b/%0b/%0b exp=1/0/0", busy, op_ready, res_valid);
    end
    rst = 1'b0;
    #1;
    op_valid = 1'b0;
    checks++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0 || op_ready !== 1'b0 || res_valid !== 1'b0) begin
      failures++; $display("FAIL midrst_ctrl got=%0b/%0b/%0b/%0b exp=1/0/0/0", cfg_ready, busy, op_ready, res_valid);
    end
    checks++;
    if (mac_in1 !== 0 || mac_in2 !== 0 || mac_in3 !== 0 || mac_mode !== 0 || res_flags !== 0) begin
      failures++; $display("FAIL midrst_regs got=%0h,%0h,%0h,%0h,%b exp=0", mac_in1, mac_in2, mac_in3, mac_mode, res_flags);
    end
    @(negedge clk);
    rst = 1'b1;
    opa[0] = 3; opb[0] = 4;
    run_job(3'b010, 1, 128'd10, 0, 0);
    checks++;
    if (res_data !== 128'd22 || res_flags !== 4'b0000 || lat !== 4) begin
      failures++; $display("FAIL midrst_new_job got=%0h/%b/%0d exp=16/0000/4", res_data, res_flags, lat);
    end
    finish_job();
  endtask

  task automatic test_max_len();
    for (int i = 0; i < 16; i++) begin
      opa[i] = 1; opb[i] = 1;
    end
    run_job(3'b011, 15, 128'd0, 0, 0);
    checks++;
    if (res_data !== 128'd15 || res_flags !== 4'b0000) begin
      failures++; $display("FAIL max_result got=%0h/%b exp=f/0000", res_data, res_flags);
    end
    checks++;
    if (lat !== 46) begin failures++; $display("FAIL max_latency got=%0d exp=46", lat); end
    finish_job();
  endtask

  initial begin
    rst = 1'b0; cfg_valid = 1'b0; cfg_mode = '0; cfg_rm = '0; cfg_k = '0; cfg_acc_init = '0;
    op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0;
    test_reset();
    test_basic();
    test_zero_illegal();
    test_stall();
    test_sticky();
    test_reset_mid();
    test_max_len();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
